serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Serial-to-parallel receiver: the far end of a link driven by a right-shifting register that emits bit 0 first.
- Detects a start bit, shifts in WIDTH data bits LSB-first, optionally checks a parity bit, checks the stop bit, then presents the word in parallel with a one-cycle valid pulse.
- Bit timing comes from an external one-cycle strobe, so the block is clock-rate agnostic.
- Sits between the serial line and the parallel register and display logic of the lab datapath.

Parameters:
- WIDTH, 8, number of data bits per frame (2..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; the line is sampled only on edges where bit_en=1.
- sin  input  1  serial line; idles at 1.
- parity_en  input  1  1 = frame carries a parity bit after the data bits.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- data  output  WIDTH  last good frame's data word; holds until the next good frame.
- valid  output  1  one-cycle pulse when data updates.
- parity_err  output  1  qualifies valid; 1 = parity mismatch on this word.
- frame_err  output  1  one-cycle pulse when the stop bit reads 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset, with rst=1 at a rising edge:
  - state=IDLE; data=0; valid=0; parity_err=0; frame_err=0; busy=0; shift register=0; bit counter=0.
  - Reset wins over every other event. Reset mid-frame discards the partial frame and emits no pulses.
- When bit_en=0, the FSM and shift register hold. valid and frame_err still deassert, because they are single-cycle pulses.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - On bit_en=1 with sin=0: go to DATA, cnt=0, latch parity_en and parity_odd into internal config.
  - sin=1 stays in IDLE.
  - Config changes mid-frame have no effect.
- DATA:
  - On each bit_en: shreg <= {sin, shreg[WIDTH-1:1]}, so the first received bit ends in bit 0.
  - Also update running parity: par ^= sin.
  - When cnt==WIDTH-1 on that strobe: go to PARITY if latched parity_en=1, else go to STOP. Otherwise cnt++.
- PARITY: on bit_en, store the parity bit and go to STOP.
- STOP, on bit_en:
  - sin=1: data <= shreg; valid=1 for the next cycle. parity_err = (latched parity_en) & (par ^ pbit ^ latched parity_odd), i.e. 1 when the total count of ones over data+pbit is odd for even parity, or even for odd parity.
  - sin=0: frame_err=1 for the next cycle; data, valid and parity_err unchanged.
  - In both cases return to IDLE.
- Timing:
  - Latency: valid asserts in the cycle immediately after the clock edge that sampled the stop bit.
  - parity_err is meaningful only when valid=1 and reads 0 otherwise.
- Back-to-back frames: the start bit of the next frame may arrive on the very next bit_en after the stop bit. No idle bit is required.
- Stop bit 0 followed by a held-low line (break) is not a start. After a framing error the FSM requires sin=1 on at least one strobe in IDLE before it accepts a new start bit. Implement with an armed flag that is cleared on frame_err and set by sin=1 in IDLE.
- busy goes to 1 on the edge that accepts the start bit and returns to 0 on the edge that samples the stop bit.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.

Decomposition:
- Shared package serial_pkg, shared with the matching transmitter:
  - state enum {IDLE, DATA, PARITY, STOP};
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1;
  - function parity_of(word, odd).
- One sub-module: rx_shift_reg, a WIDTH-bit right shift register with serial-in at the MSB, a shift enable and synchronous clear. The FSM, parity and error logic stay in the top module.

Test Plan:
- Frame 0xA5, parity off. Bits start 0, then 1,0,1,0,0,1,0,1, then stop 1, one bit_en every 4 clks -> single valid pulse, data=8'hA5, parity_err=0, busy high for exactly 9 strobes.
- 0x3C with even parity, pbit=0 -> valid, parity_err=0. Repeat with pbit=1 -> valid, parity_err=1, data=8'h3C. Repeat with odd parity, pbit=1 -> parity_err=0.
- 0x5A with stop bit 0 -> frame_err pulse, no valid, data keeps previous 8'hA5. Line held 0 for 3 strobes -> stays IDLE. Then line 1, then a good 0x01 frame -> valid, data=8'h01.
- rst=1 asserted after 4 data bits of a frame -> all outputs 0 the next cycle. A following full frame 0xFF -> data=8'hFF, with no residue from the aborted frame.
- Two back-to-back frames 0x12 and 0x34 with no idle gap, bit_en every clk -> two valid pulses exactly 10 clks apart, data 8'h12 then 8'h34.
- Toggle parity_en and sin while bit_en=0 mid-frame -> no state change. Result matches the config latched at the start bit.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver and its matching transmitter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Widest supported data word; narrower words are zero-extended by the caller.
  localparam int MAX_WIDTH = 16;

  // Parity bit a transmitter appends so the total count of ones over
  // data+parity is even (odd=0) or odd (odd=1).
  function automatic logic parity_of(input logic [MAX_WIDTH-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// WIDTH-bit right shift register, serial-in at the MSB, so the first bit ends in bit 0.
// Latency: one clock per shift; o_q reflects the shifted value after the edge.
// Backpressure: none; shifts only when i_shift=1, i_clr has priority.
//
// Ports:
//   clk     - clock
//   i_clr   - synchronous clear to all-zero (wins over i_shift)
//   i_shift - shift enable
//   i_sin   - serial input, enters at bit WIDTH-1
//   o_q     - parallel register contents
module rx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= {i_sin, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// Latency: valid/frame_err pulse in the cycle right after the edge that samples the stop bit.
// Backpressure: none; the line is sampled only on bit_en strobes, state holds otherwise.
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   bit_en             - one-cycle bit strobe
//   sin                - serial line (idles high)
//   parity_en          - frame carries a parity bit (latched at the start bit)
//   parity_odd         - 1 = odd parity, 0 = even (latched at the start bit)
//   data               - last good frame's word, held until the next good frame
//   valid              - one-cycle pulse when data updates
//   parity_err         - qualifies valid; 1 = parity mismatch on this word
//   frame_err          - one-cycle pulse when the stop bit reads 0
//   busy               - frame in progress
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             sin,
  input  logic             parity_en,
  input  logic             parity_odd,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_par, w_par_nxt;
  logic             r_pbit, w_pbit_nxt;
  logic             r_cfg_pen, w_cfg_pen_nxt;
  logic             r_cfg_odd, w_cfg_odd_nxt;
  // Cleared by a framing error so a held-low line (break) is not taken as a start.
  logic             r_armed, w_armed_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, w_valid_nxt;
  logic             r_perr, w_perr_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_clr;
  logic [WIDTH-1:0] w_shreg;

  rx_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .i_clr   (rst | w_clr),
    .i_shift (w_shift),
    .i_sin   (sin),
    .o_q     (w_shreg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_par     <= 1'b0;
      r_pbit    <= 1'b0;
      r_cfg_pen <= 1'b0;
      r_cfg_odd <= 1'b0;
      r_armed   <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_par     <= w_par_nxt;
      r_pbit    <= w_pbit_nxt;
      r_cfg_pen <= w_cfg_pen_nxt;
      r_cfg_odd <= w_cfg_odd_nxt;
      r_armed   <= w_armed_nxt;
      r_valid   <= w_valid_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      if (w_load) begin
        r_data <= w_shreg;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_par_nxt     = r_par;
    w_pbit_nxt    = r_pbit;
    w_cfg_pen_nxt = r_cfg_pen;
    w_cfg_odd_nxt = r_cfg_odd;
    w_armed_nxt   = r_armed;
    w_valid_nxt   = 1'b0;
    w_perr_nxt    = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_clr         = 1'b0;

    if (bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (sin == LINE_IDLE) begin
            w_armed_nxt = 1'b1;
          end else if (sin == START_BIT && r_armed) begin
            w_state_nxt   = DATA;
            w_cnt_nxt     = '0;
            w_par_nxt     = 1'b0;
            w_pbit_nxt    = 1'b0;
            w_clr         = 1'b1;
            w_cfg_pen_nxt = parity_en;
            w_cfg_odd_nxt = parity_odd;
          end
        end

        DATA: begin
          w_shift   = 1'b1;
          w_par_nxt = r_par ^ sin;
          if (r_cnt == LAST_BIT) begin
            w_state_nxt = r_cfg_pen ? PARITY : STOP;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end

        PARITY: begin
          w_pbit_nxt  = sin;
          w_state_nxt = STOP;
        end

        STOP: begin
          if (sin == STOP_BIT) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
            // Running data parity, received parity bit and the expected sense
            // XOR to 1 exactly when the ones count is wrong.
            w_perr_nxt  = r_cfg_pen & (r_par ^ r_pbit ^ r_cfg_odd);
          end else begin
            w_ferr_nxt  = 1'b1;
            w_armed_nxt = 1'b0;
          end
          w_state_nxt = IDLE;
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         bit_en;
  logic         sin;
  logic         parity_en;
  logic         parity_odd;
  logic [W-1:0] data;
  logic         valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // Observed pulses, collected by the monitor.
  logic [W-1:0] got_data[$];
  logic         got_perr[$];
  int           got_cyc[$];
  int           got_ferr = 0;
  int           busy_strobes = 0;
  int           cyc = 0;

  // Reference expectations.
  logic [W-1:0] exp_data_q[$];
  logic         exp_perr_q[$];
  int           exp_ferr = 0;
  logic [W-1:0] exp_data = '0;

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .sin        (sin),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      got_data.push_back(data);
      got_perr.push_back(parity_err);
      got_cyc.push_back(cyc);
    end
    if (frame_err) got_ferr++;
    if (bit_en && busy) busy_strobes++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe carrying bit b, then gap-1 idle clocks with a noisy line.
  task automatic strobe(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    for (int i = 1; i < gap; i++) begin
      sin = 1'($urandom);
      tick();
    end
  endtask

  // Drives a full frame; config is scrambled right after the start bit.
  task automatic send_frame(input logic [W-1:0] word, input logic pen, input logic odd,
                            input logic pbit, input logic stop, input int gap);
    parity_en  = pen;
    parity_odd = odd;
    strobe(1'b0, gap);
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    for (int i = 0; i < W; i++) strobe(word[i], gap);
    if (pen) strobe(pbit, gap);
    strobe(stop, gap);
  endtask

  // Expected outcome from the frame's content alone.
  task automatic model_frame(input logic [W-1:0] word, input logic pen, input logic odd,
                             input logic pbit, input logic stop);
    int ones;
    logic perr;
    ones = $countones(word) + (pen ? int'(pbit) : 0);
    perr = pen && ((ones % 2) != (odd ? 1 : 0));
    if (stop) begin
      exp_data_q.push_back(word);
      exp_perr_q.push_back(perr);
      exp_data = word;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_pulses(input string tag);
    int n;
    tick();
    tick();
    chk({tag, "_nvalid"}, got_data.size(), exp_data_q.size());
    chk({tag, "_nferr"}, got_ferr, exp_ferr);
    n = (got_data.size() < exp_data_q.size()) ? got_data.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, got_data[i], exp_data_q[i]);
      chk({tag, "_perr"}, got_perr[i], exp_perr_q[i]);
    end
    chk({tag, "_hold"}, data, exp_data);
    chk({tag, "_idle"}, {busy, valid, parity_err, frame_err}, 4'b0000);
    got_data.delete();
    got_perr.delete();
    got_cyc.delete();
    exp_data_q.delete();
    exp_perr_q.delete();
    got_ferr = 0;
    exp_ferr = 0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic pen, odd, pb, st;
    int gap;

    rst = 1'b1; bit_en = 1'b0; sin = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) tick();
    chk("reset_outs", {data, busy, valid, parity_err, frame_err}, '0);
    rst = 1'b0;
    tick();

    // Plain frame, slow strobe; busy must span start-accept to stop-sample.
    busy_strobes = 0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("a5");
    chk("a5_busy_strobes", busy_strobes, 9);

    // Framing error keeps the old word.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pulses("ferr");
    chk("ferr_keeps_a5", data, 8'hA5);

    // Break: held-low line is not a start until the line goes high.
    repeat (3) strobe(1'b0, 2);
    chk("break_not_busy", busy, 1'b0);
    strobe(1'b1, 2);
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    model_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("after_break");

    // Parity cases on 0x3C (four ones).
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    model_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    check_pulses("even_ok");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    model_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    check_pulses("even_bad");
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 3);
    model_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    check_pulses("odd_ok");

    // Reset after four data bits.
    parity_en = 1'b0;
    strobe(1'b0, 2);
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 2);
    rst = 1'b1;
    tick();
    chk("midreset_outs", {data, busy, valid, parity_err, frame_err}, '0);
    rst = 1'b0;
    exp_data = '0;
    sin = 1'b1;
    tick();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    model_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pulses("after_reset");

    // Back-to-back frames, strobe every clock.
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    model_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    model_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("b2b_spacing", (got_cyc.size() == 2) ? got_cyc[1] - got_cyc[0] : -1, 10);
    check_pulses("b2b");

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      w   = W'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      pb  = 1'($urandom);
      st  = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(1, 3);
      send_frame(w, pen, odd, pb, st, gap);
      model_frame(w, pen, odd, pb, st);
      if (!st) strobe(1'b1, 1);
      check_pulses("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
